// File: rtl/uart_tx_interface.sv
// Transmit-side buffer between the Crypter and UART_TX: a small byte FIFO drained
// one byte at a time over a start/done handshake, with an optional trailing EOT byte.
module uart_tx_interface #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 2,
  parameter logic [7:0]  EOT_CHAR = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       send_eot,
  input  logic       tx_done_tick,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       full,
  output logic       busy,
  output logic       overflow,
  output logic       eot_sent
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t            state, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic              eot_pending, eot_pending_next;
  logic              is_eot, is_eot_next;
  logic              push, pop;
  logic              tx_start_next, full_next, busy_next, overflow_next, eot_sent_next;
  logic [7:0]        tx_data_next;

  // FIFO storage; contents are don't-care after reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Next-state and next-output logic for the FSM and FIFO bookkeeping
  always_comb begin
    state_next       = state;
    tx_data_next     = tx_data;
    tx_start_next    = 1'b0;
    eot_sent_next    = 1'b0;
    is_eot_next      = is_eot;
    eot_pending_next = eot_pending;
    pop              = 1'b0;
    push             = wr_en && !full && !eot_pending;
    overflow_next    = wr_en && (full || eot_pending);

    if (send_eot) eot_pending_next = 1'b1;

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop           = 1'b1;
          tx_data_next  = mem[rd_ptr];
          tx_start_next = 1'b1;
          state_next    = START;
        end else if (eot_pending) begin
          tx_data_next     = EOT_CHAR;
          eot_pending_next = 1'b0;
          is_eot_next      = 1'b1;
          tx_start_next    = 1'b1;
          state_next       = START;
        end
      end
      START: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done_tick) begin
          state_next = IDLE;
          if (is_eot) begin
            eot_sent_next = 1'b1;
            is_eot_next   = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    wr_ptr_next = push ? ADDR_W'(wr_ptr + 1'b1) : wr_ptr;
    rd_ptr_next = pop  ? ADDR_W'(rd_ptr + 1'b1) : rd_ptr;

    case ({push, pop})
      2'b10:   count_next = CNT_W'(count + 1'b1);
      2'b01:   count_next = CNT_W'(count - 1'b1);
      default: count_next = count;
    endcase

    full_next = (count_next == CNT_W'(DEPTH));
    busy_next = (state_next != IDLE) || (count_next != '0) || eot_pending_next;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      eot_pending <= 1'b0;
      is_eot      <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      full        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      eot_sent    <= 1'b0;
    end else begin
      state       <= state_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      count       <= count_next;
      eot_pending <= eot_pending_next;
      is_eot      <= is_eot_next;
      tx_start    <= tx_start_next;
      tx_data     <= tx_data_next;
      full        <= full_next;
      busy        <= busy_next;
      overflow    <= overflow_next;
      eot_sent    <= eot_sent_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_interface.sv
// Bench for uart_tx_interface: directed vector table, hand-written corner sequences
// and randomized traffic compared cycle by cycle against a queue-based reference model.
module tb_uart_tx_interface;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  EOT   = 8'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, send_eot, tx_done_tick;
  logic [7:0] data_in;
  logic       tx_start, full, busy, overflow, eot_sent;
  logic [7:0] tx_data;

  uart_tx_interface #(.DEPTH(4), .ADDR_W(2), .EOT_CHAR(8'd4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .send_eot(send_eot),
    .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data), .full(full),
    .busy(busy), .overflow(overflow), .eot_sent(eot_sent)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; the link is either free or carrying one byte
  logic [7:0] mq[$];
  logic [7:0] txlog[$];
  bit         m_pend, m_link, m_just, m_cur_eot, m_ov, m_eot;
  logic [7:0] m_data;

  task automatic model_reset();
    mq.delete();
    m_pend = 0; m_link = 0; m_just = 0; m_cur_eot = 0; m_ov = 0; m_eot = 0;
    m_data = 8'h00;
  endtask

  task automatic model_edge(input bit w, input logic [7:0] d, input bit s, input bit dn);
    bit old_pend, launch, launched_eot;
    old_pend = m_pend;
    launch = 0;
    launched_eot = 0;
    m_ov  = w && (mq.size() == DEPTH || old_pend);
    m_eot = 0;
    if (!m_link) begin
      if (mq.size() > 0) begin
        m_data = mq.pop_front();
        launch = 1;
      end else if (old_pend) begin
        m_data = EOT;
        launched_eot = 1;
        m_cur_eot = 1;
        launch = 1;
      end
    end else if (!m_just && dn) begin
      m_link = 0;
      if (m_cur_eot) begin
        m_eot = 1;
        m_cur_eot = 0;
      end
    end
    m_just = launch;
    if (launch) m_link = 1;
    if (w && !m_ov) mq.push_back(d);
    m_pend = launched_eot ? 1'b0 : (old_pend | s);
  endtask

  task automatic model_compare();
    chk("tx_start", 32'(tx_start), 32'(m_just));
    chk("tx_data",  32'(tx_data),  32'(m_data));
    chk("overflow", 32'(overflow), 32'(m_ov));
    chk("eot_sent", 32'(eot_sent), 32'(m_eot));
    chk("full",     32'(full),     32'(mq.size() == DEPTH));
    chk("busy",     32'(busy),     32'(m_link || mq.size() != 0 || m_pend));
  endtask

  // One clock: drive inputs, advance model on the edge, compare 1 time unit later
  task automatic step(input bit w, input logic [7:0] d, input bit s, input bit dn);
    wr_en = w; data_in = d; send_eot = s; tx_done_tick = dn;
    @(posedge clk);
    model_edge(w, d, s, dn);
    #1;
    model_compare();
    if (tx_start) txlog.push_back(tx_data);
    wr_en = 0; data_in = 8'h00; send_eot = 0; tx_done_tick = 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_full"},     32'(full),     32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_eot_sent"}, 32'(eot_sent), 32'd0);
  endtask

  task automatic do_reset();
    rst = 0; wr_en = 0; data_in = 0; send_eot = 0; tx_done_tick = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    model_reset();
    txlog.delete();
    rst = 1;
  endtask

  task automatic check_log(input string name, input logic [7:0] exp[$]);
    chk({name, "_len"}, 32'(txlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < txlog.size(); i++)
      chk(name, 32'(txlog[i]), 32'(exp[i]));
  endtask

  typedef struct {
    bit         w;
    logic [7:0] d;
    bit         s;
    bit         dn;
    bit         e_start;
    logic [7:0] e_data;
    bit         e_busy;
    bit         e_ov;
    bit         e_eot;
  } vec_t;

  vec_t       vecs[11];
  logic [7:0] exp_q[$];
  int         lat;

  initial begin
    // Two queued bytes, EOT request, then a write blocked by the pending EOT
    vecs[0]  = '{1, 8'h10, 0, 0, 0, 8'h00, 1, 0, 0};
    vecs[1]  = '{1, 8'h20, 1, 0, 1, 8'h10, 1, 0, 0};
    vecs[2]  = '{1, 8'h30, 0, 0, 0, 8'h10, 1, 1, 0};
    vecs[3]  = '{0, 8'h00, 0, 1, 0, 8'h10, 1, 0, 0};
    vecs[4]  = '{0, 8'h00, 0, 0, 1, 8'h20, 1, 0, 0};
    vecs[5]  = '{0, 8'h00, 0, 1, 0, 8'h20, 1, 0, 0};
    vecs[6]  = '{0, 8'h00, 0, 1, 0, 8'h20, 1, 0, 0};
    vecs[7]  = '{0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0};
    vecs[8]  = '{0, 8'h00, 0, 0, 0, 8'h04, 1, 0, 0};
    vecs[9]  = '{0, 8'h00, 0, 1, 0, 8'h04, 0, 0, 1};
    vecs[10] = '{0, 8'h00, 0, 0, 0, 8'h04, 0, 0, 0};

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].d, vecs[i].s, vecs[i].dn);
      chk($sformatf("vec%0d_start", i), 32'(tx_start), 32'(vecs[i].e_start));
      chk($sformatf("vec%0d_data", i),  32'(tx_data),  32'(vecs[i].e_data));
      chk($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].e_busy));
      chk($sformatf("vec%0d_ov", i),    32'(overflow), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_eot", i),   32'(eot_sent), 32'(vecs[i].e_eot));
    end

    // Single byte: start latency, long stall, busy clears right after done
    do_reset();
    step(1, 8'hA5, 0, 0);
    lat = 0;
    do begin
      step(0, 8'h00, 0, 0);
      lat++;
    end while (!tx_start && lat < 20);
    chk("a5_latency_cycles", 32'(lat + 1), 32'd2);
    chk("a5_data", 32'(tx_data), 32'hA5);
    repeat (9) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("a5_busy_after_done", 32'(busy), 32'd0);

    // Done ticks in IDLE and during START are ignored
    step(0, 8'h00, 0, 1);
    step(1, 8'h5C, 0, 0);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("start_done_ignored", 32'(tx_start), 32'd0);
    repeat (3) step(0, 8'h00, 0, 0);
    chk("still_waiting_busy", 32'(busy), 32'd1);
    step(0, 8'h00, 0, 1);

    // Stalled link: fill, overflow, then drain in order
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      step(1, 8'(i), 0, 0);
      if (i == 5) chk("fill_full", 32'(full), 32'd1);
    end
    chk("fill_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 40; i++) step(0, 8'h00, 0, (i % 3) == 2);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("fill_order", exp_q);

    // Asynchronous reset in the middle of a byte
    do_reset();
    step(1, 8'h61, 0, 0);
    step(1, 8'h62, 0, 0);
    step(1, 8'h63, 0, 0);
    step(0, 8'h00, 0, 0);
    #3;
    rst = 0;
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    txlog.delete();
    repeat (6) step(0, 8'h00, 0, 0);
    chk("midreset_no_start", 32'(txlog.size()), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);

    // Write coinciding with an IDLE pop, repeated across pointer wrap
    do_reset();
    step(1, 8'h11, 0, 0);
    step(1, 8'h12, 0, 0);
    step(1, 8'h13, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step(0, 8'h00, 0, 1);
      step(1, 8'(8'h14 + k), 0, 0);
      step(0, 8'h00, 0, 0);
    end
    for (int i = 0; i < 30; i++) step(0, 8'h00, 0, i[0]);
    exp_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'h11 + i));
    check_log("wrap_order", exp_q);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) == 0);
    for (int i = 0; i < 60; i++) step(0, 8'h00, 0, 1);
    chk("random_drained_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
